// File: rtl/mod_add_pkg.sv
// Shared types and helpers for the arbitrated modulo-(2^N-K) adder.
package mod_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        LOAD  = 2'd3
    } state_t;

    localparam int ID_W = 1;

    function automatic logic [31:0] mod_m(input int n, input logic [31:0] k);
        return (32'd1 << n) - k;
    endfunction

endpackage

// File: rtl/mod_add_core.sv
// Combinational modulo-(2^N-K) adder built from two Kogge-Stone prefix trees.
module mod_add_core
    import mod_add_pkg::*;
#(
    parameter int N_BIT = 7
) (
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic [N_BIT-1:0] k,
    output logic [N_BIT-1:0] sum,
    output logic             err
);

    function automatic logic [N_BIT:0] ks_add(
        input logic [N_BIT-1:0] x,
        input logic [N_BIT-1:0] y
    );
        logic [N_BIT-1:0] g;
        logic [N_BIT-1:0] p;
        logic [N_BIT-1:0] gn;
        logic [N_BIT-1:0] pn;
        logic [N_BIT-1:0] hp;
        g  = x & y;
        p  = x ^ y;
        hp = p;
        for (int d = 1; d < N_BIT; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < N_BIT; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        return {g[N_BIT-1], hp ^ {g[N_BIT-2:0], 1'b0}};
    endfunction

    logic [N_BIT:0]   m;
    logic [N_BIT-1:0] h;
    logic [N_BIT-1:0] maj;
    logic [N_BIT-1:0] cs;
    logic [N_BIT-1:0] s_ab;
    logic [N_BIT:0]   s_hc;
    logic             c_abk;

    assign m = (N_BIT+1)'(mod_m(N_BIT, 32'(k)));

    // Carry-save a+b+K into (h, cs) so the second tree sees two operands
    assign h   = a ^ b ^ k;
    assign maj = (a & b) | (a & k) | (b & k);
    assign cs  = {maj[N_BIT-2:0], 1'b0};

    assign s_ab  = N_BIT'(ks_add(a, b));
    assign s_hc  = ks_add(h, cs);
    assign c_abk = s_hc[N_BIT] ^ maj[N_BIT-1];

    assign err = ({1'b0, a} >= m) || ({1'b0, b} >= m);

    // Carry out of a+b+K means a+b >= M; low bits are then a+b-M
    assign sum = err   ? '0 :
                 c_abk ? s_hc[N_BIT-1:0] : s_ab;

endmodule

// File: rtl/mod_add_arbiter.sv
// Two-requester round-robin front end for the shared modulo adder.
module mod_add_arbiter
    import mod_add_pkg::*;
#(
    parameter int          N_BIT   = 7,
    parameter int unsigned K_RESET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [N_BIT-1:0]  cfg_k,
    output logic              cfg_ready,
    output logic              cfg_err,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [N_BIT-1:0]  req0_a,
    input  logic [N_BIT-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [N_BIT-1:0]  req1_a,
    input  logic [N_BIT-1:0]  req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [N_BIT-1:0]  rsp_sum,
    output logic              rsp_err,
    output logic              busy
);

    state_t           state;
    logic [N_BIT-1:0] k_reg;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt;
    logic             slot_free;
    logic             cfg_legal;
    logic [N_BIT-1:0] op_a;
    logic [N_BIT-1:0] op_b;
    logic [N_BIT-1:0] core_sum;
    logic             core_err;

    always_comb begin
        slot_free = !rsp_valid || rsp_ready;
        gnt = !rst && slot_free && !cfg_valid &&
              (state == IDLE || state == RUN) &&
              (req0_valid || req1_valid);
        if (req0_valid && req1_valid)
            gnt_id = rr_ptr;
        else
            gnt_id = ID_W'(req1_valid);
        req0_ready = gnt && (gnt_id == 1'b0);
        req1_ready = gnt && (gnt_id == 1'b1);
        op_a = (gnt_id == 1'b1) ? req1_a : req0_a;
        op_b = (gnt_id == 1'b1) ? req1_b : req0_b;
        cfg_legal = !cfg_k[N_BIT-1];
        cfg_ready = !rst && (state == LOAD) && cfg_valid;
        cfg_err   = cfg_ready && !cfg_legal;
        busy      = (state != IDLE) || rsp_valid;
    end

    mod_add_core #(
        .N_BIT(N_BIT)
    ) u_core (
        .a  (op_a),
        .b  (op_b),
        .k  (k_reg),
        .sum(core_sum),
        .err(core_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_reg     <= N_BIT'(K_RESET);
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_valid)
                        state <= LOAD;
                    else if (req0_valid || req1_valid)
                        state <= RUN;
                end
                RUN: begin
                    if (cfg_valid)
                        state <= DRAIN;
                    else if (!req0_valid && !req1_valid && !rsp_valid)
                        state <= IDLE;
                end
                DRAIN: begin
                    if (slot_free)
                        state <= LOAD;
                end
                LOAD: begin
                    if (cfg_ready && cfg_legal)
                        k_reg <= cfg_k;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (gnt) begin
                rr_ptr    <= ~gnt_id;
                rsp_valid <= 1'b1;
                rsp_id    <= gnt_id;
                rsp_sum   <= core_sum;
                rsp_err   <= core_err;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Directed bench for mod_add_arbiter with N_BIT=8, K_RESET=3 (M=253).
module tb_mod_add_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [N-1:0] cfg_k = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [N-1:0] rsp_sum;
    logic         rsp_err;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    mod_add_arbiter #(
        .N_BIT  (N),
        .K_RESET(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_k     (cfg_k),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cfg_valid  = 1'b1;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready,
             cfg_ready, cfg_err, rsp_sum} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b id=%b e=%b busy=%b g=%b%b cr=%b ce=%b sum=%0d want all 0",
                     rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready,
                     cfg_ready, cfg_err, rsp_sum);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cfg_valid  = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] es;
        tick();
        req0_valid = 1'b1; req0_a = 8'd1;  req0_b = 8'd2;
        req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd20;
        rsp_ready  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL rr_grant[%0d] got %b%b want %0d", i,
                         req0_ready, req1_ready, i % 2);
            end
            if (i > 0) begin
                es = ((i - 1) % 2 == 1) ? 8'd30 : 8'd3;
                n_cmp++;
                if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 1'((i - 1) % 2), es}) begin
                    n_bad++;
                    $display("FAIL rr_result[%0d] got v=%b id=%b sum=%0d want v=1 id=%0d sum=%0d",
                             i - 1, rsp_valid, rsp_id, rsp_sum, (i - 1) % 2, es);
                end
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_sum, req0_ready, req1_ready} !== {1'b1, 1'b1, 8'd30, 2'b00}) begin
            n_bad++;
            $display("FAIL rr_last got v=%b id=%b sum=%0d g=%b%b want v=1 id=1 sum=30 g=00",
                     rsp_valid, rsp_id, rsp_sum, req0_ready, req1_ready);
        end
        tick();
        tick();
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL rr_idle got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_single();
        tick();
        req0_valid = 1'b1; req0_a = 8'd250; req0_b = 8'd10;
        rsp_ready  = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_grant got %b%b want 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b0, 8'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL single_result got v=%b id=%b sum=%0d err=%b want 1 0 7 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_consume got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        tick();
        req1_valid = 1'b1; req1_a = 8'd252; req1_b = 8'd252;
        rsp_ready  = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_grant got %b%b want 01", req0_ready, req1_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_err} !==
                {1'b0, 1'b1, 1'b1, 8'd251, 1'b0}) begin
                n_bad++;
                $display("FAIL hold[%0d] got g=%b v=%b id=%b sum=%0d err=%b want 0 1 1 251 0",
                         i, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_err);
            end
        end
        req1_a = 8'd1; req1_b = 8'd2;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_replace_grant got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 1'b1, 8'd3}) begin
            n_bad++;
            $display("FAIL hold_replace got v=%b id=%b sum=%0d want 1 1 3",
                     rsp_valid, rsp_id, rsp_sum);
        end
        tick();
    endtask

    task automatic test_back_to_back_err();
        logic [N-1:0] ta [4] = '{8'd254, 8'd0,   8'd100, 8'd252};
        logic [N-1:0] tb [4] = '{8'd1,   8'd253, 8'd50,  8'd0};
        logic [N-1:0] ts [4] = '{8'd0,   8'd0,   8'd150, 8'd252};
        logic         te [4] = '{1'b1,   1'b1,   1'b0,   1'b0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i];
            #1;
            n_cmp++;
            if (req0_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_grant[%0d] got %b want 1", i, req0_ready);
            end
            if (i > 0) begin
                n_cmp++;
                if ({rsp_valid, rsp_sum, rsp_err} !== {1'b1, ts[i-1], te[i-1]}) begin
                    n_bad++;
                    $display("FAIL b2b_result[%0d] got v=%b sum=%0d err=%b want 1 %0d %b",
                             i - 1, rsp_valid, rsp_sum, rsp_err, ts[i-1], te[i-1]);
                end
            end
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_err} !== {1'b1, ts[3], te[3]}) begin
            n_bad++;
            $display("FAIL b2b_result[3] got v=%b sum=%0d err=%b want 1 %0d %b",
                     rsp_valid, rsp_sum, rsp_err, ts[3], te[3]);
        end
        tick();
        tick();
    endtask

    task automatic test_cfg();
        int w;
        tick();
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
        rsp_ready  = 1'b0;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_pre_grant got %b want 1", req0_ready);
        end
        tick();
        cfg_valid = 1'b1; cfg_k = 8'd0;
        req0_a = 8'd200; req0_b = 8'd100;
        #1;
        n_cmp++;
        if ({req0_ready, cfg_ready, rsp_valid, rsp_sum} !== {1'b0, 1'b0, 1'b1, 8'd2}) begin
            n_bad++;
            $display("FAIL cfg_priority got g=%b cr=%b v=%b sum=%0d want 0 0 1 2",
                     req0_ready, cfg_ready, rsp_valid, rsp_sum);
        end
        tick();
        n_cmp++;
        if ({req0_ready, cfg_ready, busy, rsp_valid} !== 4'b0011) begin
            n_bad++;
            $display("FAIL cfg_drain_wait got g=%b cr=%b busy=%b v=%b want 0 0 1 1",
                     req0_ready, cfg_ready, busy, rsp_valid);
        end
        tick();
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, cfg_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL cfg_drain_consume got g=%b cr=%b want 0 0", req0_ready, cfg_ready);
        end
        tick();
        n_cmp++;
        if ({cfg_ready, cfg_err, rsp_valid, req0_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL cfg_load got cr=%b ce=%b v=%b g=%b want 1 0 0 0",
                     cfg_ready, cfg_err, rsp_valid, req0_ready);
        end
        tick();
        cfg_valid = 1'b0;
        #1;
        n_cmp++;
        if ({cfg_ready, req0_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL cfg_resume got cr=%b g=%b want 0 1", cfg_ready, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_err} !== {1'b1, 8'd44, 1'b0}) begin
            n_bad++;
            $display("FAIL cfg_k0_sum got v=%b sum=%0d err=%b want 1 44 0",
                     rsp_valid, rsp_sum, rsp_err);
        end
        tick();
        cfg_valid = 1'b1; cfg_k = 8'd200;
        w = 0;
        do begin
            tick();
            w++;
        end while (!cfg_ready && w < 6);
        n_cmp++;
        if ({cfg_ready, cfg_err} !== 2'b11) begin
            n_bad++;
            $display("FAIL cfg_illegal got cr=%b ce=%b after %0d cycles want 1 1",
                     cfg_ready, cfg_err, w);
        end
        tick();
        cfg_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd200; req0_b = 8'd100;
        #1;
        n_cmp++;
        if ({cfg_err, req0_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL cfg_err_pulse got ce=%b g=%b want 0 1", cfg_err, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_err} !== {1'b1, 8'd44, 1'b0}) begin
            n_bad++;
            $display("FAIL cfg_k_kept got v=%b sum=%0d err=%b want 1 44 0",
                     rsp_valid, rsp_sum, rsp_err);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd5;
        rsp_ready  = 1'b0;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_grant got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        cfg_valid = 1'b1; cfg_k = 8'd5;
        tick();
        n_cmp++;
        if ({busy, rsp_valid, rsp_id, rsp_sum, cfg_ready} !== {3'b111, 8'd10, 1'b0}) begin
            n_bad++;
            $display("FAIL rmid_drain got busy=%b v=%b id=%b sum=%0d cr=%b want 1 1 1 10 0",
                     busy, rsp_valid, rsp_id, rsp_sum, cfg_ready);
        end
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready,
             cfg_ready, cfg_err, rsp_sum} !== 16'h0) begin
            n_bad++;
            $display("FAIL rmid_outputs got v=%b id=%b e=%b busy=%b g=%b%b cr=%b ce=%b sum=%0d want all 0",
                     rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready,
                     cfg_ready, cfg_err, rsp_sum);
        end
        tick();
        rst = 1'b0;
        cfg_valid = 1'b0;
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req0_a = 8'd250; req0_b = 8'd10;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_post_grant got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b0, 8'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL rmid_k_restored got v=%b id=%b sum=%0d err=%b want 1 0 7 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_back_to_back_err();
        test_cfg();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
